// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the multi-port register bank.
package reg_bank_pkg;

  localparam int unsigned NB_DATA_DEF = 32;
  localparam int unsigned NB_ADDR_DEF = 5;
  localparam int unsigned REG_ZERO    = 0;

  // An address names a real, writable register: not r0 and inside the bank.
  function automatic logic addr_valid(input int unsigned addr, input int unsigned depth);
    return (addr != REG_ZERO) && (addr < depth);
  endfunction

  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy flags: flush beats claim, claim beats write-clear.
module reg_scoreboard
  import reg_bank_pkg::*;
#(
  parameter int unsigned NB_ADDR    = NB_ADDR_DEF,
  parameter int unsigned BANK_DEPTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_claim_valid,
  input  logic [NB_ADDR-1:0]    i_claim_reg,
  input  logic                  i_clear_valid,
  input  logic [NB_ADDR-1:0]    i_clear_reg,
  output logic [BANK_DEPTH-1:0] o_busy_vec
);

  logic [BANK_DEPTH-1:0] busy_q;
  logic [BANK_DEPTH-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (i_flush) begin
      busy_d = '0;
    end else begin
      if (i_clear_valid) busy_d[i_clear_reg] = 1'b0;
      if (i_claim_valid) busy_d[i_claim_reg] = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign o_busy_vec = busy_q;

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-port register bank with optional write bypass, busy scoreboard and debug read.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int unsigned NB_DATA    = NB_DATA_DEF,
  parameter int unsigned NB_ADDR    = NB_ADDR_DEF,
  parameter int unsigned BANK_DEPTH = 32,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_reg_write,
  input  logic [NB_ADDR-1:0]            i_write_reg,
  input  logic [NB_DATA-1:0]            i_write_data,
  input  logic [NUM_READ*NB_ADDR-1:0]   i_read_reg,
  output logic [NUM_READ*NB_DATA-1:0]   o_read_data,
  output logic [NUM_READ-1:0]           o_read_busy,
  input  logic                          i_claim_valid,
  input  logic [NB_ADDR-1:0]            i_claim_reg,
  input  logic                          i_flush,
  input  logic [NB_ADDR-1:0]            i_dbg_addr,
  output logic [NB_DATA-1:0]            o_dbg_data,
  output logic [BANK_DEPTH-1:0]         o_busy_vec
);

  logic [NB_DATA-1:0] regs_q [BANK_DEPTH];
  logic               wr_ok;
  logic               claim_ok;
  logic               dbg_ok;

  assign wr_ok    = i_reg_write   && addr_valid(32'(i_write_reg), BANK_DEPTH);
  assign claim_ok = i_claim_valid && addr_valid(32'(i_claim_reg), BANK_DEPTH);
  assign dbg_ok   = addr_valid(32'(i_dbg_addr), BANK_DEPTH);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      regs_q <= '{default: '0};
    end else if (wr_ok) begin
      regs_q[i_write_reg] <= i_write_data;
    end
  end

  // Debug read samples storage only, never the in-flight write.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)    o_dbg_data <= '0;
    else if (dbg_ok) o_dbg_data <= regs_q[i_dbg_addr];
    else             o_dbg_data <= '0;
  end

  reg_scoreboard #(
    .NB_ADDR    (NB_ADDR),
    .BANK_DEPTH (BANK_DEPTH)
  ) u_scoreboard (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_flush       (i_flush),
    .i_claim_valid (claim_ok),
    .i_claim_reg   (i_claim_reg),
    .i_clear_valid (wr_ok),
    .i_clear_reg   (i_write_reg),
    .o_busy_vec    (o_busy_vec)
  );

  for (genvar g = 0; g < int'(NUM_READ); g++) begin : g_rd
    logic [NB_ADDR-1:0] addr;
    logic               valid;
    logic               hit;
    logic               claim_hit;

    assign addr      = i_read_reg[slice_lo(g, NB_ADDR) +: NB_ADDR];
    assign valid     = addr_valid(32'(addr), BANK_DEPTH);
    assign hit       = (BYPASS != 0) && wr_ok && (i_write_reg == addr);
    assign claim_hit = claim_ok && (i_claim_reg == addr);

    // Bypass is gated by reset so a held reset reads all zeros.
    assign o_read_data[slice_lo(g, NB_DATA) +: NB_DATA] =
      !i_reset ? '0 :
      hit      ? i_write_data :
      valid    ? regs_q[addr] : '0;

    assign o_read_busy[g] = valid && o_busy_vec[addr] && !(hit && !claim_hit);
  end

endmodule
